// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, the fetch stage, the memory stage and the unified memory.
// The arbiter connects through the master modport; requesters and memory see the slave view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_done;
  logic [DATA_W-1:0] ex_rdata;
  logic              stall_if;
  logic              stall_mem;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, ex_mem_read, ex_mem_write, ex_addr, ex_wdata, mem_rdata,
    output if_valid, if_rdata, ex_done, ex_rdata, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, ex_mem_read, ex_mem_write, ex_addr, ex_wdata, mem_rdata,
    input  if_valid, if_rdata, ex_done, ex_rdata, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter: one transaction at a time, fetch and data served
// alternately on conflict, fixed-latency reads, stall outputs for the fetch and memory stages.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master port_io
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] LAT_INIT  = 4'(MEM_LAT - 1);
  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              store_q, store_d;
  logic              last_grant_q, last_grant_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ex_rdata_q, ex_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              ex_done_q, ex_done_d;
  logic              data_req_s, any_req_s, grant_data_s;

  // On a conflict the grant goes to whoever was not served last.
  assign data_req_s   = port_io.ex_mem_read | port_io.ex_mem_write;
  assign any_req_s    = data_req_s | port_io.if_req;
  assign grant_data_s = data_req_s & (~port_io.if_req | (last_grant_q == OWN_FETCH));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) state_d = ISSUE;
        else           state_d = IDLE;
      end
      ISSUE: begin
        if (store_q) state_d = DONE;
        else         state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_cnt_q == 4'd0) state_d = DONE;
        else                   state_d = RD_WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; every output is computed one cycle ahead and registered
  always_comb begin
    owner_d      = owner_q;
    store_d      = store_q;
    last_grant_d = last_grant_q;
    lat_cnt_d    = lat_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    ex_rdata_d   = ex_rdata_q;
    if_valid_d   = 1'b0;
    ex_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          owner_d  = grant_data_s;
          store_d  = grant_data_s & port_io.ex_mem_write;
          mem_en_d = 1'b1;
          mem_we_d = grant_data_s & port_io.ex_mem_write;
          if (grant_data_s) begin
            mem_addr_d  = port_io.ex_addr;
            mem_wdata_d = port_io.ex_wdata;
          end else begin
            mem_addr_d  = port_io.if_addr;
            mem_wdata_d = mem_wdata_q;
          end
        end else begin
          owner_d = owner_q;
        end
      end
      ISSUE: begin
        if (store_q) begin
          ex_done_d = 1'b1;
        end else begin
          lat_cnt_d = LAT_INIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          if (owner_q == OWN_DATA) begin
            ex_rdata_d = port_io.mem_rdata;
            ex_done_d  = 1'b1;
          end else begin
            if_rdata_d = port_io.mem_rdata;
            if_valid_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      DONE:    last_grant_d = owner_q;
      default: last_grant_d = last_grant_q;
    endcase
  end

  // Datapath and output registers; last_grant resets to data so fetch wins the first conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWN_FETCH;
      store_q      <= 1'b0;
      last_grant_q <= OWN_DATA;
      lat_cnt_q    <= 4'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      ex_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      ex_done_q    <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      store_q      <= store_d;
      last_grant_q <= last_grant_d;
      lat_cnt_q    <= lat_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      ex_rdata_q   <= ex_rdata_d;
      if_valid_q   <= if_valid_d;
      ex_done_q    <= ex_done_d;
    end
  end

  assign port_io.mem_en    = mem_en_q;
  assign port_io.mem_we    = mem_we_q;
  assign port_io.mem_addr  = mem_addr_q;
  assign port_io.mem_wdata = mem_wdata_q;
  assign port_io.if_valid  = if_valid_q;
  assign port_io.if_rdata  = if_rdata_q;
  assign port_io.ex_done   = ex_done_q;
  assign port_io.ex_rdata  = ex_rdata_q;
  assign port_io.stall_if  = port_io.if_req & ~if_valid_q;
  assign port_io.stall_mem = data_req_s & ~ex_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance driven from a vector table and
// hand sequences, plus a MEM_LAT=1 instance for the short-latency load.
module tb_mem_port_arbiter;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  typedef struct {
    logic        if_req;
    logic        rd;
    logic        wr;
    logic [15:0] if_addr;
    logic [15:0] ex_addr;
    logic [15:0] ex_wdata;
    logic        exp_data;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_if = 16'h0000;
  logic [15:0] exp_ex = 16'h0000;

  logic [15:0] mem_arr [0:255];
  logic [3:0]  a_cnt = 4'd0;
  logic [7:0]  a_idx = 8'd0;
  logic [3:0]  b_cnt = 4'd0;
  logic [7:0]  b_idx = 8'd0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .port_io(bus_a.master));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .port_io(bus_b.master));

  // Memory model: read data is valid only in the one cycle MEM_LAT cycles after the issue
  always @(posedge clk) begin
    if (bus_a.mem_en && bus_a.mem_we) mem_arr[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
    if (bus_a.mem_en && !bus_a.mem_we) begin
      a_cnt <= 4'(LAT_A);
      a_idx <= bus_a.mem_addr[7:0];
    end else if (a_cnt != 4'd0) begin
      a_cnt <= a_cnt - 4'd1;
    end
    if (bus_b.mem_en && !bus_b.mem_we) begin
      b_cnt <= 4'(LAT_B);
      b_idx <= bus_b.mem_addr[7:0];
    end else if (b_cnt != 4'd0) begin
      b_cnt <= b_cnt - 4'd1;
    end
  end
  assign bus_a.mem_rdata = (a_cnt == 4'd1) ? mem_arr[a_idx] : 16'hDEAD;
  assign bus_b.mem_rdata = (b_cnt == 4'd1) ? mem_arr[b_idx] : 16'hDEAD;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic if_req, input logic rd, input logic wr,
                              input logic [15:0] if_addr, input logic [15:0] ex_addr,
                              input logic [15:0] ex_wdata, input logic exp_data,
                              input logic exp_we, input logic [15:0] exp_addr,
                              input logic [15:0] exp_rdata, input int exp_lat);
    vec_t v;
    v.if_req = if_req;     v.rd = rd;             v.wr = wr;
    v.if_addr = if_addr;   v.ex_addr = ex_addr;   v.ex_wdata = ex_wdata;
    v.exp_data = exp_data; v.exp_we = exp_we;     v.exp_addr = exp_addr;
    v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic apply_a(input vec_t v);
    bus_a.if_req       = v.if_req;
    bus_a.if_addr      = v.if_addr;
    bus_a.ex_mem_read  = v.rd;
    bus_a.ex_mem_write = v.wr;
    bus_a.ex_addr      = v.ex_addr;
    bus_a.ex_wdata     = v.ex_wdata;
  endtask

  task automatic idle_a();
    bus_a.if_req       = 1'b0;
    bus_a.ex_mem_read  = 1'b0;
    bus_a.ex_mem_write = 1'b0;
    @(negedge clk);
  endtask

  // Inputs were applied in an IDLE cycle; n counts cycles after the sampling edge
  task automatic check_txn(input vec_t v);
    logic seen;
    logic pulse_if, pulse_ex;
    seen = 1'b0;
    for (int n = 1; n <= 12 && !seen; n++) begin
      @(negedge clk);
      pulse_if = (n == v.exp_lat) && !v.exp_data;
      pulse_ex = (n == v.exp_lat) && v.exp_data;
      if (n == 1) begin
        chk1("issue_en", bus_a.mem_en, 1'b1);
        chk1("issue_we", bus_a.mem_we, v.exp_we);
        chk16("issue_addr", bus_a.mem_addr, v.exp_addr);
        if (v.exp_we) chk16("issue_wdata", bus_a.mem_wdata, v.ex_wdata);
      end else begin
        chk1("en_single_cycle", bus_a.mem_en, 1'b0);
      end
      chk1("stall_if", bus_a.stall_if, v.if_req & ~pulse_if);
      chk1("stall_mem", bus_a.stall_mem, (v.rd | v.wr) & ~pulse_ex);
      chk1("one_pulse", bus_a.if_valid & bus_a.ex_done, 1'b0);
      if (bus_a.if_valid || bus_a.ex_done) begin
        seen = 1'b1;
        chki("latency", n, v.exp_lat);
        chk1("owner", bus_a.ex_done, v.exp_data);
        if (!v.exp_we) begin
          if (v.exp_data) exp_ex = v.exp_rdata;
          else            exp_if = v.exp_rdata;
        end
        chk16("if_rdata", bus_a.if_rdata, exp_if);
        chk16("ex_rdata", bus_a.ex_rdata, exp_ex);
      end
    end
    chk1("txn_pulse_seen", seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    vec_t v;
    logic seen;
    logic expect_data;
    int   pulses;
    int   last_n;

    for (int i = 0; i < 256; i++) mem_arr[i] = {8'hB0, 8'(i)};
    mem_arr[16] = 16'hA5A5;
    mem_arr[3]  = 16'h00FF;

    //          if rd wr if_addr    ex_addr    wdata      data we exp_addr   rdata      lat
    vecs[0] = mk(1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 16'h0010, 16'hA5A5, 4);
    vecs[1] = mk(0, 0, 1, 16'h0000, 16'h0200, 16'h1234, 1, 1, 16'h0200, 16'h0000, 2);
    vecs[2] = mk(0, 1, 1, 16'h0000, 16'h0201, 16'hBEEF, 1, 1, 16'h0201, 16'h0000, 2);
    vecs[3] = mk(0, 1, 0, 16'h0000, 16'h0200, 16'h0000, 1, 0, 16'h0200, 16'h1234, 4);
    vecs[4] = mk(1, 1, 0, 16'h0020, 16'h0001, 16'h0000, 0, 0, 16'h0020, 16'hB020, 4);
    vecs[5] = mk(1, 1, 0, 16'h0030, 16'h0040, 16'h0000, 1, 0, 16'h0040, 16'hB040, 4);
    vecs[6] = mk(1, 0, 1, 16'h0060, 16'h0050, 16'h7777, 0, 0, 16'h0060, 16'hB060, 4);
    vecs[7] = mk(1, 1, 0, 16'h0070, 16'h0050, 16'h0000, 1, 0, 16'h0050, 16'hB050, 4);
    vecs[8] = mk(0, 1, 0, 16'h0000, 16'h0201, 16'h0000, 1, 0, 16'h0201, 16'hBEEF, 4);
    vecs[9] = mk(1, 0, 0, 16'h0003, 16'h0000, 16'h0000, 0, 0, 16'h0003, 16'h00FF, 4);

    rst_n = 1'b0;
    bus_b.if_req = 1'b0; bus_b.if_addr = 16'h0000; bus_b.ex_mem_read = 1'b0;
    bus_b.ex_mem_write = 1'b0; bus_b.ex_addr = 16'h0000; bus_b.ex_wdata = 16'h0000;
    v = mk(1, 0, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0, 16'h0040, 16'hB040, 4);
    apply_a(v);
    repeat (3) @(negedge clk);

    // Reset holds every registered output at zero even with a request pending
    chk1("rst_mem_en", bus_a.mem_en, 1'b0);
    chk1("rst_mem_we", bus_a.mem_we, 1'b0);
    chk16("rst_mem_addr", bus_a.mem_addr, 16'h0000);
    chk16("rst_mem_wdata", bus_a.mem_wdata, 16'h0000);
    chk1("rst_if_valid", bus_a.if_valid, 1'b0);
    chk1("rst_ex_done", bus_a.ex_done, 1'b0);
    chk16("rst_if_rdata", bus_a.if_rdata, 16'h0000);
    chk16("rst_ex_rdata", bus_a.ex_rdata, 16'h0000);
    rst_n = 1'b1;
    check_txn(v);
    idle_a();

    for (int i = 0; i < 10; i++) begin
      apply_a(vecs[i]);
      check_txn(vecs[i]);
      idle_a();
    end

    // Reset during RD_WAIT aborts the read at once; the held request restarts afterwards
    v = vecs[0];
    apply_a(v);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("abort_mem_en", bus_a.mem_en, 1'b0);
    chk16("abort_mem_addr", bus_a.mem_addr, 16'h0000);
    chk16("abort_if_rdata", bus_a.if_rdata, 16'h0000);
    chk16("abort_ex_rdata", bus_a.ex_rdata, 16'h0000);
    exp_if = 16'h0000;
    exp_ex = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1("abort_no_valid", bus_a.if_valid, 1'b0);
      chk1("abort_no_done", bus_a.ex_done, 1'b0);
      chk1("abort_no_en", bus_a.mem_en, 1'b0);
    end
    rst_n = 1'b1;
    check_txn(v);

    // Continuous conflict from reset: fetch first, then strict alternation every 5 cycles
    rst_n = 1'b0;
    apply_a(mk(1, 1, 0, 16'h0020, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    @(negedge clk);
    rst_n = 1'b1;
    expect_data = 1'b0;
    pulses = 0;
    last_n = 0;
    for (int n = 1; n <= 80 && pulses < 10; n++) begin
      @(negedge clk);
      chk1("conf_one_pulse", bus_a.if_valid & bus_a.ex_done, 1'b0);
      if (bus_a.if_valid || bus_a.ex_done) begin
        chk1("conf_owner", bus_a.ex_done, expect_data);
        chki("conf_gap", n - last_n, (pulses == 0) ? 4 : 5);
        if (bus_a.ex_done) chk16("conf_ex_rdata", bus_a.ex_rdata, 16'hB040);
        else               chk16("conf_if_rdata", bus_a.if_rdata, 16'hB020);
        expect_data = ~expect_data;
        last_n = n;
        pulses++;
      end
    end
    chki("conf_count", pulses, 10);
    idle_a();

    // Short-latency instance: load completes 3 cycles after the sampling edge
    bus_b.ex_mem_read = 1'b1;
    bus_b.ex_addr = 16'h0003;
    seen = 1'b0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk1("b_issue_en", bus_b.mem_en, 1'b1);
        chk16("b_issue_addr", bus_b.mem_addr, 16'h0003);
      end
      if (bus_b.ex_done) begin
        seen = 1'b1;
        chki("b_latency", n, 3);
        chk16("b_ex_rdata", bus_b.ex_rdata, 16'h00FF);
        chk1("b_stall_mem", bus_b.stall_mem, 1'b0);
      end else begin
        chk1("b_stall_mem", bus_b.stall_mem, 1'b1);
      end
    end
    chk1("b_pulse_seen", seen, 1'b1);
    bus_b.ex_mem_read = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between the fetch stage (instruction reads) and the memory stage (data reads and writes, driven by the decoded memRead/memWrite control signals). It runs one memory transaction at a time through a small FSM with a fixed-latency read counter. Fetch and data requests are served alternately when both are pending. It drives the stall signals that freeze the fetch stage and the memory stage until their access completes.

## Interface
- ADDR_W, 16: memory address width
- DATA_W, 16: memory data width (one instruction word)
- MEM_LAT, 2: cycles from a read issue (mem_en=1, mem_we=0) until mem_rdata is valid; legal range 1..15
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch stage requests an instruction word
- if_addr  in  ADDR_W  fetch address (PC)
- if_valid  out  1  one-cycle pulse, if_rdata holds the fetched word
- if_rdata  out  DATA_W  fetched instruction, registered
- ex_mem_read  in  1  memory-stage load (memRead)
- ex_mem_write  in  1  memory-stage store (memWrite)
- ex_addr  in  ADDR_W  data address
- ex_wdata  in  DATA_W  store data
- ex_done  out  1  one-cycle pulse, data access complete
- ex_rdata  out  DATA_W  load data, registered
- stall_if  out  1  = if_req & ~if_valid
- stall_mem  out  1  = (ex_mem_read | ex_mem_write) & ~ex_done
- mem_en, mem_we  out  1 each  memory strobe and write enable, registered
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT, DONE.
- IDLE: sample requests. A data request is ex_mem_read | ex_mem_write. If ex_mem_write is high, the access is a store, and a store wins over ex_mem_read if both are high.
- Arbitration when both a data request and if_req are pending: the grant goes to the requester not served last (last_grant bit). A lone request is granted directly. Go to ISSUE, latching owner, op, address and wdata.
- ISSUE: mem_en=1 for exactly one cycle, with mem_we=1 for a store and 0 for a read. A store goes to DONE. A read loads lat_cnt=MEM_LAT-1 and goes to RD_WAIT.
- RD_WAIT: decrement lat_cnt. When lat_cnt==0, capture mem_rdata into if_rdata or ex_rdata according to the owner, then go to DONE.
- DONE: pulse if_valid or ex_done according to the owner, update last_grant, and return to IDLE.
- Requesters hold their request and its operands until the done/valid pulse. A request still asserted after the pulse is treated as a new request.
- Input changes during ISSUE, RD_WAIT or DONE have no effect on the transaction in flight.
- The stores never update if_rdata. ex_rdata holds its last load value across stores.

## Timing
- Reset (async, rst_n=0) sets all of the following, immediately and independent of clk:
  - state to IDLE
  - mem_en, mem_we, if_valid and ex_done to 0
  - mem_addr, mem_wdata, if_rdata, ex_rdata, lat_cnt to 0
  - last_grant to data, so fetch wins the first conflict
- Reset mid-transaction aborts it with no done pulse. The requester re-requests after reset.
- Request seen in IDLE at edge k:
  - mem_en is high in cycle k+1.
  - Store: ex_done is high in cycle k+2. Latency 2.
  - Read: data is captured at the end of cycle k+1+MEM_LAT, and valid/done is high in cycle k+2+MEM_LAT. With MEM_LAT=2 the latency is 4.
- Throughput: one transaction per 3 (store) or MEM_LAT+3 (read) cycles, counting the IDLE cycle.
- stall_if and stall_mem are combinational from the inputs and the done pulses, so they drop in the same cycle as the pulse.
- At most one of if_valid and ex_done is high in any cycle.

## Test plan
- Reset: hold rst_n=0 while if_req=1 -> all outputs 0. Release reset -> mem_en=1 two edges later with mem_addr=if_addr.
- Lone fetch, MEM_LAT=2, if_addr=0x0010, memory returns 0xA5A5 -> if_valid pulses 4 cycles after the sample edge, if_rdata=0xA5A5, stall_if high until that cycle.
- Store: ex_mem_write=1, ex_addr=0x0200, ex_wdata=0x1234 -> exactly one cycle with mem_en=1, mem_we=1, addr 0x0200, data 0x1234, then ex_done pulses the next cycle. Raising ex_mem_read=1 at the same time still gives mem_we=1.
- Conflict: if_req and ex_mem_read held continuously after reset -> grants alternate fetch, data, fetch, data. No starvation over 10 transactions.
- Reset asserted in RD_WAIT -> mem_en=0 at once, no if_valid or ex_done pulse. After release the held request restarts from ISSUE.
- MEM_LAT=1 build: load at 0x0003 returning 0x00FF -> ex_done 3 cycles after the sample edge with ex_rdata=0x00FF.
